// File: rtl/incr_pkg.sv
// -----------------------------------------------------------------------------
// incr_pkg
// Shared types and defaults for the shared-incrementer arbiter.
//   incr_arb_state_t : response-slot state (EMPTY / FULL)
//   INCR_WIDTH_DEF   : default data width
//   INCR_NUM_REQ_DEF : default number of requesters
// -----------------------------------------------------------------------------
package incr_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } incr_arb_state_t;

    localparam int INCR_WIDTH_DEF   = 8;
    localparam int INCR_NUM_REQ_DEF = 4;

endpackage

// File: rtl/incrementer.sv
// -----------------------------------------------------------------------------
// incrementer
// Combinational +1 datapath, shared by all requesters of the arbiter.
//   a     in  WIDTH : source value
//   y     out WIDTH : a + 1, modulo 2^WIDTH
//   carry out 1     : carry out of the addition (a was all ones)
// -----------------------------------------------------------------------------
module incrementer #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y,
    output logic             carry
);

    assign {carry, y} = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};

endmodule

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin grant selection. The search begins at ptr
// and wraps from N-1 to 0; the first asserted request wins. The pointer
// register lives in the parent.
//   req     in  N  : request vector
//   ptr     in  IW : index where the search starts
//   en      in  1  : allow a grant this cycle
//   gnt     out N  : one-hot grant (zero when en is low or no request)
//   gnt_idx out IW : encoded winner (valid whenever any req bit is set)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic        found;
    int unsigned idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            // Rotated index: ptr + k, wrapped without a modulo operator.
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[IW'(idx)]) begin
                found   = 1'b1;
                gnt_idx = IW'(idx);
            end
        end
        if (en && found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/incr_share_arbiter.sv
// -----------------------------------------------------------------------------
// incr_share_arbiter
// Shares one incrementer among NUM_REQ requesters. A round-robin arbiter picks
// one valid request per cycle and registers value+1 into a one-deep response
// slot tagged with the requester index.
//
// Build option: define INCR_ARB_SATURATE_EN to make an all-ones input produce
// an all-ones result instead of wrapping to zero (resp_overflow is 1 either way).
//
// Ports:
//   clock         in  1             : clock, rising edge
//   reset         in  1             : synchronous active-high reset
//   req_valid     in  NUM_REQ       : requester i has a value pending
//   req_data      in  NUM_REQ*WIDTH : requester i value at [i*WIDTH +: WIDTH]
//   req_ready     out NUM_REQ       : one-hot accept of requester i this cycle
//   resp_valid    out 1             : response slot holds a result
//   resp_ready    in  1             : consumer takes the response this cycle
//   resp_data     out WIDTH         : incremented value
//   resp_id       out ID_W          : index of the originating requester
//   resp_overflow out 1             : source value was all ones
// -----------------------------------------------------------------------------
module incr_share_arbiter
    import incr_pkg::*;
#(
    parameter  int WIDTH   = INCR_WIDTH_DEF,
    parameter  int NUM_REQ = INCR_NUM_REQ_DEF,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [WIDTH-1:0]         resp_data,
    output logic [ID_W-1:0]          resp_id,
    output logic                     resp_overflow
);

    incr_arb_state_t  state_q, state_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic [ID_W-1:0]  resp_id_q, resp_id_d;
    logic             resp_ovf_q, resp_ovf_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic [WIDTH-1:0]   req_arr [NUM_REQ];
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               accept;
    logic               arb_en;
    logic               handshake;
    logic [WIDTH-1:0]   sel_data;
    logic [WIDTH-1:0]   inc_sum;
    logic               inc_carry;
    logic [WIDTH-1:0]   inc_result;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_arr[gi] = req_data[gi*WIDTH +: WIDTH];
    end

    // A full slot can be drained and refilled in the same cycle.
    assign accept = (state_q == EMPTY) || resp_ready;
    // Reset blocks grants combinationally so nothing is accepted in that cycle.
    assign arb_en = accept && !reset;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .en     (arb_en),
        .gnt    (gnt),
        .gnt_idx(gnt_idx)
    );

    assign req_ready = gnt;
    assign handshake = |gnt;
    assign sel_data  = req_arr[gnt_idx];

    incrementer #(
        .WIDTH(WIDTH)
    ) u_inc (
        .a    (sel_data),
        .y    (inc_sum),
        .carry(inc_carry)
    );

`ifdef INCR_ARB_SATURATE_EN
    assign inc_result = inc_carry ? {WIDTH{1'b1}} : inc_sum;
`else
    assign inc_result = inc_sum;
`endif

    always_comb begin
        state_d     = state_q;
        resp_data_d = resp_data_q;
        resp_id_d   = resp_id_q;
        resp_ovf_d  = resp_ovf_q;
        rr_ptr_d    = rr_ptr_q;
        if (handshake) begin
            state_d     = FULL;
            resp_data_d = inc_result;
            resp_id_d   = gnt_idx;
            // Carry out of +1 is set exactly when the source was all ones.
            resp_ovf_d  = inc_carry;
            rr_ptr_d    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (state_q == FULL && resp_ready) begin
            // Drain only; payload registers keep their stale values.
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= EMPTY;
            resp_data_q <= '0;
            resp_id_q   <= '0;
            resp_ovf_q  <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            resp_data_q <= resp_data_d;
            resp_id_q   <= resp_id_d;
            resp_ovf_q  <= resp_ovf_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign resp_valid    = (state_q == FULL);
    assign resp_data     = resp_data_q;
    assign resp_id       = resp_id_q;
    assign resp_overflow = resp_ovf_q;

endmodule

// File: tb/tb_incr_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_incr_share_arbiter
// Scoreboard bench: the driver predicts grants from the round-robin rule and
// queues expected responses; a negedge monitor checks whatever the DUT presents.
// -----------------------------------------------------------------------------
module tb_incr_share_arbiter;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           resp_valid;
    logic           resp_ready;
    logic [W-1:0]   resp_data;
    logic [IDW-1:0] resp_id;
    logic           resp_overflow;

    always #5 clock = ~clock;

    incr_share_arbiter #(
        .WIDTH  (W),
        .NUM_REQ(N)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_id      (resp_id),
        .resp_overflow(resp_overflow)
    );

    typedef struct {
        int data;
        int id;
        bit ovf;
    } resp_t;

    resp_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    m_ptr = 0;
    bit    m_full = 1'b0;
    int    val[N];

    function automatic int expected_inc(input int v);
        if (v == 255) begin
`ifdef INCR_ARB_SATURATE_EN
            return 255;
`else
            return 0;
`endif
        end
        return v + 1;
    endfunction

    // Drive one cycle (called at posedge+1), check req_ready just before the
    // next edge, update the reference model, and advance to posedge+1.
    task automatic apply(input bit rst, input logic [N-1:0] vld, input bit rr, output int gout);
        logic [N-1:0] exp_rdy;
        int g;
        int idx;
        reset      = rst;
        req_valid  = vld;
        resp_ready = rr;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = val[i][W-1:0];
        #8;
        g = -1;
        exp_rdy = '0;
        if (!rst && (!m_full || rr)) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && vld[idx]) g = idx;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        n_cmp++;
        if (req_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL req_ready: got %b expected %b (rst=%0b vld=%b rr=%0b)", req_ready, exp_rdy, rst, vld, rr);
        end
        if (rst) begin
            exp_q.delete();
            m_full = 1'b0;
            m_ptr  = 0;
        end else if (g >= 0) begin
            exp_q.push_back('{data: expected_inc(val[g]), id: g, ovf: (val[g] == 255)});
            m_full = 1'b1;
            m_ptr  = (g + 1) % N;
        end else if (rr) begin
            m_full = 1'b0;
        end
        $display("txn t=%0t rst=%0b vld=%b rr=%0b req_ready=%b grant=%0d", $time, rst, vld, rr, req_ready, g);
        gout = g;
        @(posedge clock);
        #1;
    endtask

    // Monitor: whatever the DUT presents must match the scoreboard head.
    always @(negedge clock) begin
        n_cmp++;
        if (resp_valid !== (exp_q.size() != 0)) begin
            n_err++;
            $display("FAIL resp_valid: got %b expected %0b", resp_valid, exp_q.size() != 0);
        end
        if (resp_valid === 1'b1 && exp_q.size() != 0) begin
            n_cmp++;
            if (int'(resp_data) != exp_q[0].data || int'(resp_id) != exp_q[0].id || resp_overflow !== exp_q[0].ovf) begin
                n_err++;
                $display("FAIL resp_payload: got data=%02h id=%0d ovf=%b expected data=%02h id=%0d ovf=%0b",
                         resp_data, resp_id, resp_overflow, exp_q[0].data, exp_q[0].id, exp_q[0].ovf);
            end
            if (resp_ready === 1'b1) void'(exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        reset      = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b0;
        req_data   = '0;
        for (int i = 0; i < N; i++) val[i] = 0;
        @(posedge clock);
        #1;

        // Reset, then single requester 0 with 0x3C.
        apply(1'b1, 4'b0000, 1'b0, g);
        apply(1'b1, 4'b0000, 1'b0, g);
        val[0] = 8'h3C;
        apply(1'b0, 4'b0001, 1'b0, g);
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_data !== 8'h3D || resp_id !== 2'd0 || resp_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL single_req: got v=%b data=%02h id=%0d ovf=%b expected v=1 data=3d id=0 ovf=0",
                     resp_valid, resp_data, resp_id, resp_overflow);
        end
        apply(1'b0, 4'b0000, 1'b1, g);

        // Round-robin with all requesters valid, pointer freshly reset.
        apply(1'b1, 4'b0000, 1'b0, g);
        for (int i = 0; i < N; i++) val[i] = i;
        for (int c = 0; c < 8; c++) begin
            apply(1'b0, 4'b1111, 1'b1, g);
            n_cmp++;
            if (g != c % N) begin
                n_err++;
                $display("FAIL rr_order: got grant %0d expected %0d", g, c % N);
            end
        end

        // Backpressure while FULL, then drain+refill in one cycle.
        for (int c = 0; c < 3; c++) apply(1'b0, 4'b1111, 1'b0, g);
        apply(1'b0, 4'b1111, 1'b1, g);

        // Overflow on all-ones input.
        for (int i = 0; i < N; i++) val[i] = 255;
        for (int c = 0; c < 3; c++) apply(1'b0, 4'b1111, 1'b1, g);

        // Reset while FULL with backpressure and requesters valid.
        for (int i = 0; i < N; i++) val[i] = 16 * i + 5;
        apply(1'b0, 4'b1111, 1'b0, g);
        apply(1'b1, 4'b1111, 1'b0, g);
        apply(1'b1, 4'b1111, 1'b0, g);
        apply(1'b0, 4'b1111, 1'b1, g);
        n_cmp++;
        if (g != 0) begin
            n_err++;
            $display("FAIL post_reset_grant: got %0d expected 0", g);
        end

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] v;
            bit rr;
            bit rst;
            for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 9) < 7);
            rr  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 49) == 0);
            apply(rst, v, rr, g);
            if (g >= 0) val[g] = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255));
        end

        for (int c = 0; c < 3; c++) apply(1'b0, 4'b0000, 1'b1, g);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/incr_share_arbiter.md
# incr_share_arbiter

Shares one `incrementer` datapath among `NUM_REQ` requesters. Each requester presents a value through a valid/ready handshake. A round-robin arbiter picks one request per cycle and registers `value + 1` into a one-deep response slot, tagged with the requester index. The block sits between requester-side counter/pointer logic and a single downstream consumer of incremented values.

## Interface
- `WIDTH`, default 8: data width of requests and responses.
- `NUM_REQ`, default 4: number of requesters; must be ≥ 2.
- `ID_W`, derived as `$clog2(NUM_REQ)`: width of the response tag; not overridable.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req_valid`  in  NUM_REQ: requester i has a value pending.
- `req_data`  in  NUM_REQ×WIDTH: value from requester i; held stable while `req_valid[i]` is high and not yet accepted.
- `req_ready`  out  NUM_REQ: one-hot or zero; bit i high means requester i's request is accepted this cycle.
- `resp_valid`  out  1: response slot holds a result.
- `resp_ready`  in  1: consumer accepts the response this cycle.
- `resp_data`  out  WIDTH: incremented value.
- `resp_id`  out  ID_W: index of the requester that produced `resp_data`.
- `resp_overflow`  out  1: the source value was all ones.

## Operation
- States:
  - EMPTY: `resp_valid` = 0.
  - FULL: `resp_valid` = 1.
- Accept condition: `accept = (state == EMPTY) || resp_ready`. In FULL this allows a drain and a refill in the same cycle.
- Grant selection:
  - Round-robin over the asserted `req_valid` bits.
  - Search starts at pointer `rr_ptr` and wraps from NUM_REQ-1 to 0.
  - The first asserted index found is granted.
- Handshake: `req_ready[g] = accept && req_valid[g]` for the granted index g; all other bits are 0. `req_ready` is combinational and never depends on `req_ready` itself.
- On a handshake with grant g:
  - `resp_data <= req_data[g] + 1`, computed by the `incrementer` instance; wraps modulo 2^WIDTH by default.
  - `resp_overflow <= &req_data[g]`.
  - `resp_id <= g`.
  - `rr_ptr <= (g == NUM_REQ-1) ? 0 : g+1`.
  - Next state is FULL.
- FULL with `resp_ready` = 1 and no request: next state is EMPTY; the data registers hold their old values.
- FULL with `resp_ready` = 0: all response registers hold, `req_ready` is all zero, `rr_ptr` holds.
- No request in EMPTY: state stays EMPTY and `rr_ptr` holds.
- `req_valid` may drop without a handshake. The arbiter re-evaluates every cycle and takes no lock.

## Timing
- Latency: request handshake in cycle N gives `resp_valid` = 1 with the result in cycle N+1.
- Throughput: 1 result per cycle while `resp_ready` stays high.
- Reset, applied synchronously and overriding all other inputs:
  - state = EMPTY, `resp_valid` = 0.
  - `resp_data` = 0, `resp_id` = 0, `resp_overflow` = 0.
  - `rr_ptr` = 0.
  - `req_ready` is all zero while `reset` is high.
- Reset mid-operation: a held response is dropped and not presented after reset. A request presented in the reset cycle is not accepted.
- Fairness: with all requesters continuously valid and `resp_ready` = 1, grants cycle 0,1,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 grants.

## Configuration
- `INCR_ARB_SATURATE_EN`:
  - Defined: an all-ones input yields an all-ones `resp_data` (saturating); `resp_overflow` is still 1.
  - Undefined: an all-ones input wraps to 0 and `resp_overflow` is 1.
  - Non-all-ones inputs behave identically in both builds.

## Structure
- Package `incr_pkg`:
  - `typedef enum logic {EMPTY, FULL} incr_arb_state_t`.
  - Default constants `INCR_WIDTH_DEF` = 8 and `INCR_NUM_REQ_DEF` = 4.
- Sub-module `rr_arbiter #(N)`:
  - Inputs: `req[N]`, `ptr`, `en`.
  - Outputs: one-hot `gnt[N]` and encoded `gnt_idx`.
  - Purely combinational; the pointer register stays in the parent.
- Instantiates the existing `incrementer #(WIDTH)` once. It is never duplicated per requester.

## Test plan
- Reset, single requester: hold `reset` 2 cycles, then `req_valid` = 0001, `req_data[0]` = 8'h3C.
  - `req_ready` = 0001 in the same cycle.
  - Next cycle: `resp_valid` = 1, `resp_data` = 8'h3D, `resp_id` = 0, `resp_overflow` = 0.
- Round-robin: all 4 valid, `resp_ready` = 1 for 8 cycles, `req_data[i]` = i.
  - `resp_id` sequence is 0,1,2,3,0,1,2,3.
  - `resp_data` sequence is 1,2,3,4,1,2,3,4.
- Backpressure: `resp_ready` = 0 for 3 cycles while FULL.
  - `req_ready` = 0000.
  - `resp_*` stable.
  - Raising `resp_ready` drains and refills in the same cycle.
- Overflow: `req_data` = 8'hFF.
  - Without the macro: `resp_data` = 8'h00, `resp_overflow` = 1.
  - With `INCR_ARB_SATURATE_EN`: `resp_data` = 8'hFF, `resp_overflow` = 1.
- Reset mid-operation: assert `reset` while FULL with `resp_ready` = 0 and requesters valid.
  - Next cycle: `resp_valid` = 0, `req_ready` = 0000.
  - After release, the first grant goes to requester 0.
